// File: rtl/rv_csr_pkg.sv
// Shared types and constants for the Zicsr access initiator: funct3 encodings,
// FSM states and well-known CSR addresses.
package rv_csr_pkg;

  typedef enum logic [2:0] {
    F3_RW  = 3'b001,
    F3_RS  = 3'b010,
    F3_RC  = 3'b011,
    F3_RWI = 3'b101,
    F3_RSI = 3'b110,
    F3_RCI = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_CYCLE    = 12'hc00;
  localparam logic [11:0] CSR_TIME     = 12'hc01;
  localparam logic [11:0] CSR_INSTRET  = 12'hc02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hc80;
  localparam logic [11:0] CSR_TIMEH    = 12'hc81;
  localparam logic [11:0] CSR_INSTRETH = 12'hc82;

endpackage

// File: rtl/rv_csr_alu.sv
// Combinational new-value computation for CSRRW/RS/RC and their immediate forms.
module rv_csr_alu
  import rv_csr_pkg::*;
#(
  parameter int xlen = 64
) (
  input  logic [2:0]      funct3,
  input  logic [xlen-1:0] old,
  input  logic [xlen-1:0] operand,
  output logic [xlen-1:0] new_value
);

  always_comb begin
    new_value = '0;
    case (funct3)
      F3_RW, F3_RWI: new_value = operand;
      F3_RS, F3_RSI: new_value = old | operand;
      F3_RC, F3_RCI: new_value = old & ~operand;
      default:       new_value = '0;
    endcase
  end

endmodule

// File: rtl/rv_csr_access.sv
// Zicsr access initiator: one read-modify-write on a combinational CSR responder per instruction.
// Optional RV_CSR_ACCESS_RO_CHECK_EN flags writes to read-only CSRs (csr[11:10] == 2'b11) locally.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_READ  | load strobe (if reading), capture old value / responder sigill
// ST_WRITE | store strobe (if writing and still legal)
// ST_RESP  | response held until writeback accepts it
module rv_csr_access
  import rv_csr_pkg::*;
#(
  parameter  bit rv64 = 1'b1,
  localparam int xlen = rv64 ? 64 : 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr,
  input  logic [4:0]      req_rs1,
  input  logic [xlen-1:0] req_rs1_value,
  input  logic [4:0]      req_rd,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_rd,
  output logic [xlen-1:0] rsp_value,
  output logic            rsp_sigill,
  output logic [11:0]     csr,
  output logic            load,
  output logic            store,
  output logic [xlen-1:0] store_value,
  input  logic [xlen-1:0] load_value,
  input  logic            sigill
);

  state_e          state;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [xlen-1:0] operand_q;
  logic [xlen-1:0] old_q;
  logic            do_read_q;
  logic            do_write_q;
  logic            illegal_q;

  logic            legal;
  logic            rw_form;
  logic            do_read;
  logic            do_write;
  logic            ro_hit;
  logic [xlen-1:0] operand;
  logic [xlen-1:0] old_next;
  logic [xlen-1:0] new_value;
  logic            store_go;

  always_comb begin
    legal    = (req_funct3[1:0] != 2'b00);
    rw_form  = (req_funct3[1:0] == 2'b01);
    do_read  = legal && (!rw_form || (req_rd != 5'd0));
    do_write = legal && (rw_form || (req_rs1 != 5'd0));
    operand  = req_funct3[2] ? {{(xlen-5){1'b0}}, req_rs1} : req_rs1_value;
  end

`ifdef RV_CSR_ACCESS_RO_CHECK_EN
  assign ro_hit = do_write && (req_csr[11:10] == 2'b11);
`else
  assign ro_hit = 1'b0;
`endif

  // Resolved in READ so the store strobe and data can be registered for WRITE.
  always_comb begin
    old_next = (do_read_q && !sigill) ? load_value : '0;
    store_go = do_write_q && !illegal_q && !sigill;
  end

  rv_csr_alu #(.xlen(xlen)) u_alu (
    .funct3    (funct3_q),
    .old       (old_next),
    .operand   (operand_q),
    .new_value (new_value)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rd      <= '0;
      rsp_value   <= '0;
      rsp_sigill  <= 1'b0;
      csr         <= '0;
      load        <= 1'b0;
      store       <= 1'b0;
      store_value <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      operand_q   <= '0;
      old_q       <= '0;
      do_read_q   <= 1'b0;
      do_write_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_q   <= req_funct3;
            rd_q       <= req_rd;
            operand_q  <= operand;
            do_read_q  <= do_read;
            do_write_q <= do_write;
            illegal_q  <= !legal || ro_hit;
            csr        <= req_csr;
            load       <= do_read && !ro_hit;
            req_ready  <= 1'b0;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          load        <= 1'b0;
          old_q       <= old_next;
          illegal_q   <= illegal_q | sigill;
          store       <= store_go;
          store_value <= store_go ? new_value : '0;
          state       <= ST_WRITE;
        end
        ST_WRITE: begin
          store       <= 1'b0;
          store_value <= '0;
          csr         <= '0;
          illegal_q   <= illegal_q | sigill;
          rsp_valid   <= 1'b1;
          rsp_rd      <= rd_q;
          rsp_sigill  <= illegal_q | sigill;
          rsp_value   <= (illegal_q | sigill) ? '0 : old_q;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_csr_access.sv
// Directed-vector bench for rv_csr_access with a small combinational CSR responder model.
module tb_rv_csr_access;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_csr = '0;
  logic [4:0]  req_rs1 = '0;
  logic [63:0] req_rs1_value = '0;
  logic [4:0]  req_rd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_rd;
  logic [63:0] rsp_value;
  logic        rsp_sigill;
  logic [11:0] csr;
  logic        load;
  logic        store;
  logic [63:0] store_value;
  logic [63:0] load_value;
  logic        sigill;

  logic [63:0] resp_data = '0;
  logic        bad_load = 1'b0;
  logic        bad_store = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  assign load_value = load ? resp_data : 64'd0;
  assign sigill     = (load & bad_load) | (store & bad_store);

  rv_csr_access dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct3    (req_funct3),
    .req_csr       (req_csr),
    .req_rs1       (req_rs1),
    .req_rs1_value (req_rs1_value),
    .req_rd        (req_rd),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rd        (rsp_rd),
    .rsp_value     (rsp_value),
    .rsp_sigill    (rsp_sigill),
    .csr           (csr),
    .load          (load),
    .store         (store),
    .store_value   (store_value),
    .load_value    (load_value),
    .sigill        (sigill)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One instruction end to end; counts strobes, checks latency and the held response.
  task automatic run(input string name, input logic [2:0] f3, input logic [11:0] a,
                     input logic [4:0] rs1, input logic [63:0] v, input logic [4:0] rd,
                     input int hold, input int e_lc, input int e_sc, input logic [63:0] e_sv,
                     input logic [63:0] e_val, input logic e_sig);
    int lc, sc, first, overlap, csr_bad, stable_bad;
    logic [63:0] sv;
    lc = 0; sc = 0; first = 0; overlap = 0; csr_bad = 0; stable_bad = 0; sv = '0;
    @(negedge clock);
    check({name, ".req_ready"}, req_ready, 1'b1);
    req_funct3 = f3; req_csr = a; req_rs1 = rs1; req_rs1_value = v; req_rd = rd;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    for (int c = 1; c <= 10 && first == 0; c++) begin
      if (load) lc++;
      if (store) begin sc++; sv = store_value; end
      if (load && store) overlap++;
      if ((load || store) && csr != a) csr_bad++;
      if (!store && store_value != 64'd0) csr_bad++;
      if (rsp_valid) first = c;
      else @(negedge clock);
    end
    check({name, ".latency"}, first, 3);
    check({name, ".loads"}, lc, e_lc);
    check({name, ".stores"}, sc, e_sc);
    check({name, ".store_value"}, sv, e_sv);
    check({name, ".strobe_err"}, overlap + csr_bad, 0);
    for (int h = 0; h <= hold; h++) begin
      if (!rsp_valid || rsp_rd != rd || rsp_value != e_val || rsp_sigill != e_sig
          || req_ready || load || store) stable_bad++;
      if (h == hold) rsp_ready = 1'b1;
      @(negedge clock);
    end
    rsp_ready = 1'b0;
    check({name, ".resp_stable_err"}, stable_bad, 0);
    check({name, ".rsp_rd"}, rsp_rd, rd);
    check({name, ".rsp_value"}, rsp_value, e_val);
    check({name, ".rsp_sigill"}, rsp_sigill, e_sig);
    check({name, ".done_valid"}, rsp_valid, 1'b0);
    check({name, ".done_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst.req_ready", req_ready, 1'b1);
    check("rst.rsp_valid", rsp_valid, 1'b0);
    check("rst.rsp_sigill", rsp_sigill, 1'b0);
    check("rst.rsp_value", rsp_value, 64'd0);
    check("rst.rsp_rd", rsp_rd, 5'd0);
    check("rst.strobes", {load, store}, 2'b00);
    check("rst.csr", csr, 12'd0);
    check("rst.store_value", store_value, 64'd0);
    reset = 1'b0;

    resp_data = 64'h1234;
    run("csrrs_c00", 3'b010, 12'hc00, 5'd0, 64'hdead, 5'd5, 0, 1, 0, 64'd0, 64'h1234, 1'b0);

    resp_data = 64'h77;
    run("csrrw_rd0", 3'b001, 12'h340, 5'd9, 64'hA5, 5'd0, 0, 0, 1, 64'hA5, 64'd0, 1'b0);

    resp_data = 64'hF;
    run("csrrci", 3'b111, 12'h340, 5'd3, 64'hffff, 5'd1, 0, 1, 1, 64'hC, 64'hF, 1'b0);

    resp_data = 64'h8;
    run("csrrsi", 3'b110, 12'h340, 5'd3, 64'hffff, 5'd2, 0, 1, 1, 64'hB, 64'h8, 1'b0);

    resp_data = 64'hFFFF_0000_0000_0001;
    run("csrrw_rd4", 3'b001, 12'h340, 5'd0, 64'h1, 5'd4, 0, 1, 1, 64'h1,
        64'hFFFF_0000_0000_0001, 1'b0);

    resp_data = 64'hFF;
    run("csrrc_reg", 3'b011, 12'h340, 5'd7, 64'hF0, 5'd6, 1, 1, 1, 64'h0F, 64'hFF, 1'b0);

    resp_data = 64'h5; bad_store = 1'b1;
`ifdef RV_CSR_ACCESS_RO_CHECK_EN
    run("csrrw_c01", 3'b001, 12'hc01, 5'd0, 64'h7, 5'd0, 0, 0, 0, 64'd0, 64'd0, 1'b1);
`else
    run("csrrw_c01", 3'b001, 12'hc01, 5'd0, 64'h7, 5'd0, 0, 0, 1, 64'h7, 64'd0, 1'b1);
`endif
    bad_store = 1'b0;

    resp_data = 64'h55;
    run("f3_100", 3'b100, 12'h340, 5'd1, 64'h1, 5'd3, 5, 0, 0, 64'd0, 64'd0, 1'b1);

    resp_data = 64'h99; bad_load = 1'b1;
    run("rs_sigill_load", 3'b010, 12'h7c0, 5'd1, 64'h1, 5'd8, 0, 1, 0, 64'd0, 64'd0, 1'b1);
    bad_load = 1'b0;

    // Reset during WRITE: the next cycle must be a clean IDLE.
    @(negedge clock);
    req_funct3 = 3'b001; req_csr = 12'h340; req_rs1_value = 64'h33; req_rd = 5'd0;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("rstw.store_in_write", store, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("rstw.store_after", store, 1'b0);
    check("rstw.rsp_valid", rsp_valid, 1'b0);
    check("rstw.req_ready", req_ready, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    check("rstw.rsp_valid_later", rsp_valid, 1'b0);

    // Reset during READ: the would-be WRITE cycle carries no store.
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstr.store_after", store, 1'b0);
    check("rstr.req_ready", req_ready, 1'b1);
    repeat (3) @(negedge clock);
    check("rstr.rsp_valid", rsp_valid, 1'b0);
    check("rstr.store_idle", store, 1'b0);

    resp_data = 64'h42;
    run("after_reset", 3'b010, 12'hc02, 5'd0, 64'd0, 5'd10, 0, 1, 0, 64'd0, 64'h42, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_csr_access.md
# rv_csr_access

Initiator side of the CSR access interface. It takes one decoded Zicsr instruction (CSRRW/RS/RC and their immediate forms) from the execute stage. It drives a read-modify-write sequence onto a combinational CSR responder (`csr`/`load`/`store`/`store_value` out, `load_value`/`sigill` in), then returns the old CSR value, or an illegal-instruction flag, to writeback over a valid/ready handshake. Exactly one instruction is in flight at a time.

## Interface
- `rv64`, default 1: selects RV64 (1) or RV32 (0).
- `xlen`, localparam, `rv64 ? 64 : 32`: data width.
- `clock`  in  1: clock, rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE.
- `req_funct3`  in  3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI. All other encodings are illegal.
- `req_csr`  in  12: CSR address.
- `req_rs1`  in  5: rs1 index, or uimm for the immediate forms.
- `req_rs1_value`  in  xlen: rs1 register value.
- `req_rd`  in  5: destination register index.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: writeback accepts the response.
- `rsp_rd`  out  5: latched `req_rd`.
- `rsp_value`  out  xlen: old CSR value. 0 if no read was performed or if `rsp_sigill` is set.
- `rsp_sigill`  out  1: illegal instruction.
- `csr`  out  12: CSR address to the responder.
- `load`  out  1: read strobe.
- `store`  out  1: write strobe.
- `store_value`  out  xlen: value to write.
- `load_value`  in  xlen: responder read data. Combinational, valid in the same cycle as `load`.
- `sigill`  in  1: responder illegal flag. Combinational, valid in the same cycle as `load` or `store`.

## Operation
- FSM states: IDLE → READ → WRITE → RESP → IDLE.
- IDLE: `req_ready` is 1. When `req_valid` is high, latch all request fields and go to READ.
- Operand: immediate forms (`funct3[2]` = 1) use `{(xlen-5)'0, req_rs1}`. Register forms use `req_rs1_value`.
- `do_read`:
  - RS, RC, RSI, RCI: always.
  - RW, RWI: only when `rd` ≠ 0.
- `do_write`:
  - RW, RWI: always.
  - RS, RC, RSI, RCI: only when `rs1`/uimm ≠ 0.
- Illegal `funct3`: treat as `do_read` = `do_write` = 0 and set the sticky illegal flag. No strobes are ever asserted for it.
- READ: drive `csr`. Assert `load` iff `do_read`.
  - If `sigill` is high, set the illegal flag.
  - Otherwise, if `do_read`, capture `old` = `load_value`.
  - `old` is 0 when no read is performed.
- WRITE: drive `csr`. Assert `store` iff `do_write` and the illegal flag is clear. `store_value` is computed from `old`:
  - RW: operand.
  - RS: `old` | operand.
  - RC: `old` & ~operand.
  - A `sigill` seen in WRITE also sets the illegal flag.
- RESP: hold `rsp_valid`, `rsp_rd`, `rsp_value` and `rsp_sigill` stable until `rsp_ready` is high, then go to IDLE.
- `load` and `store` are never high in the same cycle, and never outside READ/WRITE respectively.
- `store_value` is 0 whenever `store` is low.

## Timing
- Fixed latency: request accepted at edge N, READ in cycle N+1, WRITE in cycle N+2, `rsp_valid` first high in cycle N+3. This holds for every case, including illegal and skipped accesses.
- Throughput: at best one instruction per 4 cycles. `req_ready` is low from READ through RESP.
- `req_ready` depends only on state, never on `req_valid`.
- Response handshake: completes on the cycle where `rsp_valid` and `rsp_ready` are both high. The next request can be accepted one cycle later, in IDLE.
- Reset values: state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_sigill` 0, `rsp_value` 0, `rsp_rd` 0, `load` 0, `store` 0, `csr` 0, `store_value` 0.
- Reset mid-operation: the sequence is abandoned. No `store` is issued in the cycle after reset is sampled, and the pending response is dropped.

## Configuration
- `RV_CSR_ACCESS_RO_CHECK_EN` defined: when `csr[11:10]` = 2'b11 and `do_write`, the illegal flag is set at the start of READ. Neither `load` nor `store` is asserted.
- Not defined: no local check. The responder's `sigill` is the only source of the illegal flag, apart from illegal `funct3`.

## Structure
- Package `rv_csr_pkg` holds:
  - a `funct3` enum;
  - the FSM state enum;
  - CSR address constants (`CSR_MISA` 12'h301, `CSR_CYCLE` 12'hc00, `CSR_TIME` 12'hc01, `CSR_INSTRET` 12'hc02, `CSR_CYCLEH` 12'hc80, `CSR_TIMEH` 12'hc81, `CSR_INSTRETH` 12'hc82).
- Sub-module `rv_csr_alu`: combinational. Inputs `funct3`, `old`, operand; output new value.

## Test plan
- CSRRS `rd`=5, `rs1`=0, `csr` 12'hc00, responder `load_value` 0x1234 → exactly one `load` cycle, no `store`, response `rd`=5, `rsp_value` 0x1234, `rsp_sigill` 0, `rsp_valid` at N+3.
- CSRRW `rd`=0, `csr` 12'h340, rs1 value 0xA5, responder `sigill` 0 → no `load`, `store` with `store_value` 0xA5, `rsp_value` 0.
- CSRRCI uimm 3, old value 0xF → `store_value` 0xC. CSRRSI uimm 3, old value 0x8 → `store_value` 0xB.
- CSRRW to 12'hc01:
  - macro defined: no strobes, `rsp_sigill` 1.
  - macro undefined: responder asserts `sigill` on `store`, `rsp_sigill` 1.
- `funct3` 100 → no strobes, `rsp_sigill` 1. `rsp_ready` held low for 5 cycles → response stable; `req_ready` stays low until 1 cycle after the handshake.
- Reset asserted during WRITE → no `store` the following cycle, `rsp_valid` 0, `req_ready` 1.
